// File: rtl/bp_be_stride_table.sv
// Stride prefetcher table. Learns a per-load-PC address stride and requests a
// lookahead prefetch once the stride has repeated often enough to saturate its confidence.
package bp_be_stride_pkg;
  typedef enum logic [0:0] {e_bp_default_cfg = 1'b0} bp_params_e;

  localparam int default_vaddr_width_gp = 39;

  function automatic int vaddr_width(input bp_params_e cfg);
    case (cfg)
      e_bp_default_cfg: return default_vaddr_width_gp;
      default:          return default_vaddr_width_gp;
    endcase
  endfunction
endpackage

module bp_be_stride_table
  import bp_be_stride_pkg::*;
#(
  parameter bp_params_e bp_params_p    = e_bp_default_cfg,
  parameter int         sets_p         = 32,
  parameter int         ways_p         = 2,
  parameter int         stride_width_p = 12,
  parameter int         ctr_width_p    = 2,
  parameter int         distance_p     = 1,
  localparam int        vaddr_width_p  = vaddr_width(bp_params_p)
) (
  input  logic                      clk_i,
  input  logic                      reset_i,
  output logic                      init_done_o,
  input  logic                      v_i,
  output logic                      ready_o,
  input  logic [vaddr_width_p-1:0]  pc_i,
  input  logic [vaddr_width_p-1:0]  eff_addr_i,
  output logic                      pf_v_o,
  output logic [vaddr_width_p-1:0]  pf_addr_o,
  output logic [stride_width_p-1:0] pf_stride_o,
  output logic [vaddr_width_p-1:0]  pf_pc_o,
  input  logic                      pf_yumi_i,
  output logic                      pf_drop_o
);

  localparam int idx_w_lp = $clog2(sets_p);
  localparam int tag_w_lp = vaddr_width_p - idx_w_lp;
  localparam int ptr_w_lp = (ways_p > 1) ? $clog2(ways_p) : 1;
  localparam logic [ctr_width_p-1:0] ctr_max_lp = '1;

  typedef struct packed {
    logic                      valid;
    logic [tag_w_lp-1:0]       tag;
    logic [vaddr_width_p-1:0]  prev_addr;
    logic [stride_width_p-1:0] stride;
    logic [ctr_width_p-1:0]    ctr;
  } entry_t;

  typedef struct packed {
    logic [ptr_w_lp-1:0]       ptr;
    entry_t [ways_p-1:0]       way;
  } set_t;

  typedef enum logic [1:0] {e_reset, e_clear, e_run} state_e;

  // ---------------- control FSM ----------------
  state_e               state_q, state_d;
  logic [idx_w_lp-1:0]  clr_cnt_q, clr_cnt_d;

  always_ff @(posedge clk_i) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (reset_i) begin
      state_q   <= e_reset;
      clr_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      clr_cnt_q <= clr_cnt_d;
    end
  end

  always_comb begin
    // NOTE: defaults first so no path leaves a variable unassigned (no latch).
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    case (state_q)
      e_reset: begin
        state_d   = e_clear;
        clr_cnt_d = '0;
      end
      e_clear: begin
        clr_cnt_d = clr_cnt_q + idx_w_lp'(1);
        if (clr_cnt_q == idx_w_lp'(sets_p - 1)) state_d = e_run;
      end
      e_run:   state_d = e_run;
      default: state_d = e_reset;
    endcase
  end

  assign init_done_o = (state_q == e_run);
  assign ready_o     = (state_q == e_run);

  // ---------------- stage 0: accept and read ----------------
  set_t                     mem_q [sets_p];
  logic                     accept;
  logic [idx_w_lp-1:0]      s0_idx;
  set_t                     rd_set;

  logic                     s1_v_q;
  logic [vaddr_width_p-1:0] s1_pc_q, s1_addr_q;
  set_t                     s1_set_q;
  logic [idx_w_lp-1:0]      s1_idx;
  logic [tag_w_lp-1:0]      s1_tag;
  set_t                     wr_set;

  assign accept = v_i & ready_o;
  assign s0_idx = pc_i[idx_w_lp-1:0];
  assign s1_idx = s1_pc_q[idx_w_lp-1:0];
  assign s1_tag = s1_pc_q[vaddr_width_p-1:idx_w_lp];

  // Stage 1 writes the same set this edge: take its write data, not the stale array copy.
  assign rd_set = (s1_v_q && (s1_idx == s0_idx)) ? wr_set : mem_q[s0_idx];

  always_ff @(posedge clk_i) begin
    if (reset_i) s1_v_q <= 1'b0;
    else         s1_v_q <= accept;
  end

  // NOTE: table storage and pipeline payload carry no reset; the e_clear sweep
  // initialises the table and s1_v_q qualifies the payload.
  always_ff @(posedge clk_i) begin
    if (accept) begin
      s1_pc_q   <= pc_i;
      s1_addr_q <= eff_addr_i;
      s1_set_q  <= rd_set;
    end
  end

  always_ff @(posedge clk_i) begin
    if (state_q == e_clear)          mem_q[clr_cnt_q] <= '0;
    else if (s1_v_q && !reset_i)     mem_q[s1_idx]    <= wr_set;
  end

  // ---------------- stage 1: compare and update ----------------
  logic                      hit;
  logic [ptr_w_lp-1:0]       hit_way;
  entry_t                    upd;
  logic [vaddr_width_p-1:0]  diff, stride_sext, pf_addr;
  logic                      fits, match, pf_new;

  always_comb begin
    hit     = 1'b0;
    hit_way = '0;
    for (int w = 0; w < ways_p; w++) begin
      if (!hit && s1_set_q.way[w].valid && (s1_set_q.way[w].tag == s1_tag)) begin
        hit     = 1'b1;
        hit_way = ptr_w_lp'(w);
      end
    end
  end

  always_comb begin
    upd   = s1_set_q.way[hit_way];
    diff  = s1_addr_q - upd.prev_addr;
    // diff fits when every bit above the stride's sign bit equals that sign bit
    fits  = (&diff[vaddr_width_p-1:stride_width_p-1]) | ~(|diff[vaddr_width_p-1:stride_width_p-1]);
    match = fits && (diff[stride_width_p-1:0] == upd.stride);
    if (match) begin
      upd.ctr = (upd.ctr == ctr_max_lp) ? ctr_max_lp : upd.ctr + ctr_width_p'(1);
    end else begin
      upd.ctr    = '0;
      upd.stride = fits ? diff[stride_width_p-1:0] : '0;
    end
    upd.prev_addr = s1_addr_q;

    wr_set = s1_set_q;
    if (hit) begin
      wr_set.way[hit_way] = upd;
    end else begin
      wr_set.way[s1_set_q.ptr] = '{valid: 1'b1, tag: s1_tag, prev_addr: s1_addr_q,
                                   stride: '0, ctr: '0};
      wr_set.ptr = (s1_set_q.ptr == ptr_w_lp'(ways_p - 1)) ? '0 : s1_set_q.ptr + ptr_w_lp'(1);
    end

    pf_new      = s1_v_q && hit && match && (upd.ctr == ctr_max_lp) && (|upd.stride);
    stride_sext = {{(vaddr_width_p - stride_width_p){upd.stride[stride_width_p-1]}}, upd.stride};
    pf_addr     = s1_addr_q + vaddr_width_p'(distance_p) * stride_sext;
  end

  // ---------------- prefetch output register ----------------
  logic                      pf_v_q, pf_drop_q;
  logic [vaddr_width_p-1:0]  pf_addr_q, pf_pc_q;
  logic [stride_width_p-1:0] pf_stride_q;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      pf_v_q      <= 1'b0;
      pf_drop_q   <= 1'b0;
      pf_addr_q   <= '0;
      pf_stride_q <= '0;
      pf_pc_q     <= '0;
    end else begin
      pf_drop_q <= 1'b0;
      if (pf_new) begin
        if (pf_v_q && !pf_yumi_i) begin
          pf_drop_q <= 1'b1;
        end else begin
          pf_v_q      <= 1'b1;
          pf_addr_q   <= pf_addr;
          pf_stride_q <= upd.stride;
          pf_pc_q     <= s1_pc_q;
        end
      end else if (pf_yumi_i) begin
        pf_v_q <= 1'b0;
      end
    end
  end

  assign pf_v_o      = pf_v_q;
  assign pf_drop_o   = pf_drop_q;
  assign pf_addr_o   = pf_addr_q;
  assign pf_stride_o = pf_stride_q;
  assign pf_pc_o     = pf_pc_q;

endmodule

// File: tb/tb_bp_be_stride_table.sv
// Self-checking bench for bp_be_stride_table: directed scenarios plus random
// traffic, all compared each cycle against an arithmetic reference model.
module tb_bp_be_stride_table;
  import bp_be_stride_pkg::*;

  localparam int V    = default_vaddr_width_gp;
  localparam int SETS = 32;
  localparam int WAYS = 2;
  localparam int SW   = 12;
  localparam int CW   = 2;
  localparam int DIST = 1;
  localparam int CMAX = (1 << CW) - 1;

  localparam longint FULL = longint'(1) << V;
  localparam longint HALF = longint'(1) << (V - 1);
  localparam longint MASK = FULL - 1;
  localparam longint SMIN = -(longint'(1) << (SW - 1));
  localparam longint SMAX = (longint'(1) << (SW - 1)) - 1;

  logic          clk = 1'b0;
  logic          reset_i = 1'b1;
  logic          init_done_o, ready_o, v_i = 1'b0;
  logic [V-1:0]  pc_i = '0, eff_addr_i = '0;
  logic          pf_v_o, pf_drop_o, pf_yumi_i = 1'b0;
  logic [V-1:0]  pf_addr_o, pf_pc_o;
  logic [SW-1:0] pf_stride_o;

  always #5 clk = ~clk;

  bp_be_stride_table #(
    .bp_params_p(e_bp_default_cfg), .sets_p(SETS), .ways_p(WAYS),
    .stride_width_p(SW), .ctr_width_p(CW), .distance_p(DIST)
  ) dut (
    .clk_i(clk), .reset_i(reset_i), .init_done_o(init_done_o),
    .v_i(v_i), .ready_o(ready_o), .pc_i(pc_i), .eff_addr_i(eff_addr_i),
    .pf_v_o(pf_v_o), .pf_addr_o(pf_addr_o), .pf_stride_o(pf_stride_o),
    .pf_pc_o(pf_pc_o), .pf_yumi_i(pf_yumi_i), .pf_drop_o(pf_drop_o)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // ---------------- reference model ----------------
  bit     m_valid [SETS][WAYS];
  longint m_tag   [SETS][WAYS];
  longint m_prev  [SETS][WAYS];
  longint m_stride[SETS][WAYS];
  int     m_ctr   [SETS][WAYS];
  int     m_ptr   [SETS];

  bit     e_v, e_drop, p_v;
  longint e_addr, e_stride, e_pc, p_addr, p_stride, p_pc;

  task automatic model_clear();
    for (int s = 0; s < SETS; s++) begin
      m_ptr[s] = 0;
      for (int w = 0; w < WAYS; w++) begin
        m_valid[s][w] = 0; m_tag[s][w] = 0; m_prev[s][w] = 0;
        m_stride[s][w] = 0; m_ctr[s][w] = 0;
      end
    end
    e_v = 0; e_drop = 0; p_v = 0;
    e_addr = 0; e_stride = 0; e_pc = 0;
  endtask

  task automatic model_obs(input longint pc, input longint addr,
                           output bit fire, output longint fa, output longint fs);
    int s, hw;
    longint tag, diff, sdiff;
    bit fits, same;
    s = int'(pc % SETS); tag = pc / SETS; hw = -1;
    fire = 0; fa = 0; fs = 0;
    for (int w = 0; w < WAYS; w++)
      if (hw < 0 && m_valid[s][w] && m_tag[s][w] == tag) hw = w;
    if (hw >= 0) begin
      diff  = (addr - m_prev[s][hw]) & MASK;
      sdiff = (diff >= HALF) ? diff - FULL : diff;
      fits  = (sdiff >= SMIN) && (sdiff <= SMAX);
      same  = fits && (sdiff == m_stride[s][hw]);
      if (same) m_ctr[s][hw] = (m_ctr[s][hw] < CMAX) ? m_ctr[s][hw] + 1 : CMAX;
      else begin
        m_ctr[s][hw]    = 0;
        m_stride[s][hw] = fits ? sdiff : 0;
      end
      m_prev[s][hw] = addr;
      fire = same && (m_ctr[s][hw] == CMAX) && (m_stride[s][hw] != 0);
      fa   = (addr + DIST * m_stride[s][hw]) & MASK;
      fs   = m_stride[s][hw] & ((longint'(1) << SW) - 1);
    end else begin
      hw = m_ptr[s];
      m_valid[s][hw] = 1; m_tag[s][hw] = tag; m_prev[s][hw] = addr;
      m_stride[s][hw] = 0; m_ctr[s][hw] = 0;
      m_ptr[s] = (m_ptr[s] + 1) % WAYS;
    end
  endtask

  // Output register behaviour at the end of a cycle, given that cycle's yumi.
  task automatic model_out_edge(input bit yumi);
    e_drop = 0;
    if (p_v) begin
      if (e_v && !yumi) e_drop = 1;
      else begin
        e_v = 1; e_addr = p_addr; e_stride = p_stride; e_pc = p_pc;
      end
    end else if (yumi) e_v = 0;
  endtask

  // One run-mode cycle: compare outputs, drive inputs, advance the model.
  task automatic step(input bit v, input longint pc, input longint addr, input bit yumi_req);
    bit y, fire;
    longint fa, fs;
    check("ready", ready_o, 1);
    check("init_done", init_done_o, 1);
    check("pf_v", pf_v_o, e_v);
    check("pf_drop", pf_drop_o, e_drop);
    if (e_v) begin
      check("pf_addr", pf_addr_o, e_addr);
      check("pf_stride", pf_stride_o, e_stride);
      check("pf_pc", pf_pc_o, e_pc);
    end
    y = yumi_req && e_v;
    v_i = v; pc_i = V'(pc); eff_addr_i = V'(addr); pf_yumi_i = y;
    model_out_edge(y);
    p_v = 0;
    if (v) begin
      model_obs(pc & MASK, addr & MASK, fire, fa, fs);
      p_v = fire; p_addr = fa; p_stride = fs; p_pc = pc & MASK;
    end
    @(negedge clk);
  endtask

  task automatic do_reset(input int hold);
    reset_i = 1'b1; v_i = 1'b0; pf_yumi_i = 1'b0;
    repeat (hold) @(negedge clk);
    check("rst_pf_v", pf_v_o, 0);
    check("rst_pf_drop", pf_drop_o, 0);
    check("rst_init_done", init_done_o, 0);
    check("rst_ready", ready_o, 0);
    check("rst_pf_addr", pf_addr_o, 0);
    check("rst_pf_stride", pf_stride_o, 0);
    check("rst_pf_pc", pf_pc_o, 0);
    model_clear();
    reset_i = 1'b0;
  endtask

  task automatic wait_init();
    int cnt = 0;
    while (!init_done_o && cnt < 200) begin
      cnt++;
      @(negedge clk);
    end
    check("init_latency", cnt, SETS + 1);
  endtask

  function automatic longint rnd_va();
    return longint'({$urandom, $urandom}) & MASK;
  endfunction

  longint rp_pc[8], rp_addr[8], rp_stride[8];
  int     idx_tab[8] = '{3, 3, 3, 7, 7, 12, 20, 31};
  longint st_tab[8]  = '{64, -128, 8, 2047, -2048, 4096, 0, 2048};

  initial begin
    @(negedge clk);
    do_reset(2);
    wait_init();

    // fresh table: arbitrary lookups allocate, never prefetch
    step(1, rnd_va(), rnd_va(), 0);
    step(1, rnd_va(), rnd_va(), 0);
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    check("cold_no_pf", pf_v_o, 0);

    // stride training on consecutive cycles
    for (int k = 0; k < 5; k++) step(1, 'h100, 'h1000 + k * 'h40, 0);
    step(0, 0, 0, 0);
    check("train_pf_v", pf_v_o, 1);
    check("train_pf_addr", pf_addr_o, 'h1140);
    check("train_pf_stride", pf_stride_o, 'h040);
    check("train_pf_pc", pf_pc_o, 'h100);

    // stride change, then an out-of-range diff, then retrain from zero
    step(1, 'h100, 'h1200, 1);
    step(1, 'h100, 'h3200, 0);
    step(0, 0, 0, 0);
    check("retrain_no_pf", pf_v_o, 0);
    step(1, 'h100, 'h4240, 0);
    for (int k = 1; k <= 4; k++) step(1, 'h100, 'h4240 + k * 'h40, 0);
    step(0, 0, 0, 0);
    check("retrain_pf_addr", pf_addr_o, 'h4380);
    step(0, 0, 0, 1);

    // eviction: three tags in set 3 with two ways
    for (int k = 0; k < 4; k++) step(1, 'h003, 'h5000 + k * 'h10, 0);
    step(1, 'h023, 'h9000, 0);
    step(1, 'h043, 'hA000, 0);
    step(1, 'h003, 'h5040, 0);
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    check("evicted_no_pf", pf_v_o, 0);

    // hold / drop / replace
    for (int k = 0; k < 4; k++) begin
      step(1, 'h0A4, 'h4000 + k * 'h10, 1);
      step(1, 'h1C8, 'h8000 + k * 'h20, 1);
    end
    step(1, 'h0A4, 'h4040, 0);
    step(1, 'h1C8, 'h8080, 0);
    check("hold_pf_pc", pf_pc_o, 'h0A4);
    check("hold_no_drop", pf_drop_o, 0);
    step(0, 0, 0, 0);
    check("drop_pulse", pf_drop_o, 1);
    check("drop_keeps_first", pf_pc_o, 'h0A4);
    step(0, 0, 0, 0);
    check("drop_one_cycle", pf_drop_o, 0);
    step(0, 0, 0, 1);
    step(1, 'h0A4, 'h4050, 0);
    step(1, 'h1C8, 'h80A0, 0);
    check("deliver_first", pf_pc_o, 'h0A4);
    step(0, 0, 0, 1);
    check("deliver_second", pf_pc_o, 'h1C8);
    check("deliver_no_drop", pf_drop_o, 0);
    step(0, 0, 0, 1);
    check("delivered_empty", pf_v_o, 0);

    // random traffic
    for (int i = 0; i < 8; i++) begin
      rp_pc[i]     = ((rnd_va() << 5) | longint'(idx_tab[i])) & MASK;
      rp_addr[i]   = rnd_va();
      rp_stride[i] = st_tab[i];
    end
    for (int n = 0; n < 1500; n++) begin
      int k;
      k = int'($urandom_range(7));
      if ($urandom_range(9) == 0) rp_addr[k] = rnd_va();
      else rp_addr[k] = (rp_addr[k] + rp_stride[k]) & MASK;
      step($urandom_range(4) != 0, rp_pc[k], rp_addr[k], $urandom_range(1) == 1);
    end
    repeat (3) step(0, 0, 0, 1);

    // reset in mid-training with a firing observation in flight
    for (int k = 0; k < 4; k++) step(1, 'h2E0, 'h7000 + k * 'h80, 1);
    step(1, 'h2E0, 'h7200, 0);
    do_reset(1);
    wait_init();
    step(1, 'h2E0, 'h7280, 0);
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    check("post_reset_miss", pf_v_o, 0);

    // reset in mid-clear restarts the full sweep
    do_reset(1);
    repeat (10) @(negedge clk);
    do_reset(1);
    wait_init();
    step(1, 'h2E0, 'h7300, 0);
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
